rgb_led_ctrl: RTL and testbench
===============================

# rgb_led_ctrl

Parametrised multi-channel LED driver for the Vaman EOS S3 fabric, clocked from the 20 MHz Sys_Clk0 domain. Each channel runs in one of four modes: OFF, ON, BLINK or PWM. Configuration arrives over a valid/ready port and is committed glitch-free at the next PWM period boundary. It replaces the fixed single-LED on/blink logic with one block that drives the red, green and blue LEDs independently.

## Interface
- NUM_CH, 3: number of LED channels (red=0, green=1, blue=2 on the board)
- PWM_W, 8: PWM counter/duty width; PWM period is 2^PWM_W cycles
- BLINK_CYC, 20000000: BLINK half-period in clk cycles (1 s at 20 MHz)
- ACTIVE_LOW, 1: 1 means a lit LED is driven 0
- clk  in  1  system clock, Sys_Clk0
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  block can accept config
- cfg_ch  in  $clog2(NUM_CH)  target channel
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 PWM
- cfg_duty  in  PWM_W  PWM on-count, used in PWM mode only
- led  out  NUM_CH  registered LED drive, polarity per ACTIVE_LOW

## Operation
- Shared free-running pwm_cnt counts 0..2^PWM_W-1 and wraps.
- Shared blink_cnt counts 0..BLINK_CYC-1. On wrap, blink_ph toggles.
- Per-channel "lit" condition by mode:
  - OFF: never lit.
  - ON: always lit.
  - BLINK: lit when blink_ph=1.
  - PWM: lit when pwm_cnt < duty. duty=0 is never lit; duty=2^PWM_W-1 is lit for 2^PWM_W-1 of every 2^PWM_W cycles.
- led[i] = lit XOR ACTIVE_LOW, registered.
- Config handshake:
  - A transfer occurs on cfg_valid && cfg_ready.
  - If cfg_ch < NUM_CH: ch/mode/duty go to a single pending register, pend=1, and cfg_ready drops the next cycle.
  - If cfg_ch >= NUM_CH: the request is accepted and discarded; no pend, cfg_ready stays 1.
  - Commit: in the cycle pwm_cnt = 2^PWM_W-1 with pend=1, the pending values are written to the channel's active mode/duty and pend clears. The new setting is effective from pwm_cnt=0, and cfg_ready returns to 1 the cycle after commit.
  - A transfer accepted in the very cycle pwm_cnt = 2^PWM_W-1 does not commit in that cycle; it commits at the end of the following period.
  - cfg_* is ignored while cfg_ready=0.
- Counters never stop and are not affected by config. Mode changes do not restart blink_ph.

## Timing
- Reset values:
  - pwm_cnt=0, blink_cnt=0, blink_ph=1
  - all modes OFF, all duties 0
  - pend=0, cfg_ready=1
  - led = all ACTIVE_LOW (all LEDs dark)
- led latency: led at cycle t+1 reflects counters and active config at cycle t.
- Worst-case config latency, acceptance to effect: 2^PWM_W+1 cycles. Best case: 2 cycles.
- Reset asserted mid-pending: pending is discarded and every register returns to its reset value on the next edge.
- BLINK full period is 2*BLINK_CYC cycles. After reset, BLINK channels are lit for the first BLINK_CYC cycles.
- Arithmetic: blink_cnt width is $clog2(BLINK_CYC). pwm_cnt wraps naturally at PWM_W bits. The duty compare is unsigned.

## Structure
- Package led_ctrl_pkg holds the mode typedef (enum OFF/ON/BLINK/PWM, 2 bits) and the mode-encoding constants.
- Sub-module led_chan: per-channel active mode/duty registers, commit enable, lit mux and output register. It is instantiated NUM_CH times via generate.
- Top level holds the shared counters, the pending register and the handshake.

## Test plan
- Reset, with BLINK_CYC=10, PWM_W=4 for simulation: led=3'b111, cfg_ready=1. Hold 50 cycles: led unchanged.
- ch1 ON accepted at pwm_cnt=5:
  - cfg_ready=0 from the next cycle.
  - Commit at pwm_cnt=15.
  - led[1]=0 from the cycle after pwm_cnt=0.
  - cfg_ready=1 one cycle after commit.
- ch0 PWM duty=4:
  - Each 16-cycle period has exactly 4 cycles with led[0]=0, aligned to pwm_cnt 0..3 plus 1 cycle latency.
  - duty=0 gives led[0]=1 constantly.
- ch2 BLINK from reset: led[2] alternates 10 cycles lit, 10 dark, phase locked to blink_cnt wraps.
- cfg_ch=3: transfer completes with cfg_ready staying 1, and no led change.
- Edge cases:
  - Request held during cfg_ready=0 is ignored.
  - Transfer accepted at pwm_cnt=15 commits at the next pwm_cnt=15, not the current one.
  - rst during pend: mode stays OFF after release.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared mode encoding for the RGB LED controller
package led_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } led_mode_t;

endpackage

// File: rtl/led_chan.sv
// rtl/led_chan.sv - one LED channel: active mode/duty, lit mux, registered drive
module led_chan
    import led_ctrl_pkg::*;
#(
    parameter int PWM_W      = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_commit,
    input  logic [1:0]        i_mode,
    input  logic [PWM_W-1:0]  i_duty,
    input  logic [PWM_W-1:0]  i_pwm_cnt,
    input  logic              i_blink_ph,
    output logic              o_led
);

    led_mode_t         r_mode;
    logic [PWM_W-1:0]  r_duty;
    logic              w_lit;

    // Active settings only move at the period boundary, so PWM never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_OFF;
            r_duty <= '0;
        end else if (i_commit) begin
            r_mode <= led_mode_t'(i_mode);
            r_duty <= i_duty;
        end
    end

    always_comb begin
        w_lit = 1'b0;
        case (r_mode)
            MODE_OFF:   w_lit = 1'b0;
            MODE_ON:    w_lit = 1'b1;
            MODE_BLINK: w_lit = i_blink_ph;
            MODE_PWM:   w_lit = (i_pwm_cnt < r_duty);
            default:    w_lit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_led <= ACTIVE_LOW;
        end else begin
            o_led <= w_lit ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/rgb_led_ctrl.sv
// rtl/rgb_led_ctrl.sv - multi-channel LED driver: shared counters, pending config, handshake
module rgb_led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int PWM_W      = 8,
    parameter int BLINK_CYC  = 20000000,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [PWM_W-1:0]   cfg_duty,
    output logic [NUM_CH-1:0]  led
);

    localparam int               BLK_W    = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [PWM_W-1:0] PWM_MAX  = '1;
    localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(BLINK_CYC - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [PWM_W-1:0]  r_pwm_cnt;
    logic [BLK_W-1:0]  r_blink_cnt;
    logic              r_blink_ph;
    logic              r_pend;
    logic [CH_W-1:0]   r_pend_ch;
    logic [1:0]        r_pend_mode;
    logic [PWM_W-1:0]  r_pend_duty;
    logic              w_xfer;
    logic              w_ch_ok;
    logic              w_commit;

    // Counters free-run regardless of configuration traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt   <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_blink_cnt == BLK_MAX) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign cfg_ready = ~r_pend;
    assign w_xfer    = cfg_valid && cfg_ready;
    assign w_ch_ok   = ({1'b0, cfg_ch} < NUM_CH_L);
    assign w_commit  = r_pend && (r_pwm_cnt == PWM_MAX);

    // A request taken in the last period cycle has r_pend=0 then, so it waits a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pend_ch   <= '0;
            r_pend_mode <= MODE_OFF;
            r_pend_duty <= '0;
        end else if (w_commit) begin
            r_pend <= 1'b0;
        end else if (w_xfer && w_ch_ok) begin
            r_pend      <= 1'b1;
            r_pend_ch   <= cfg_ch;
            r_pend_mode <= cfg_mode;
            r_pend_duty <= cfg_duty;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        logic w_sel;
        assign w_sel = w_commit && (r_pend_ch == CH_W'(gi));

        led_chan #(
            .PWM_W      (PWM_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_commit   (w_sel),
            .i_mode     (r_pend_mode),
            .i_duty     (r_pend_duty),
            .i_pwm_cnt  (r_pwm_cnt),
            .i_blink_ph (r_blink_ph),
            .o_led      (led[gi])
        );
    end

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// tb/tb_rgb_led_ctrl.sv - directed self-checking bench for rgb_led_ctrl
module tb_rgb_led_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_duty;
    logic [2:0] led;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lows;

    rgb_led_ctrl #(
        .NUM_CH     (3),
        .PWM_W      (4),
        .BLINK_CYC  (10),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cyc counts edges since reset release; pwm_cnt == cyc%16, blink_cnt == cyc%10 at sample time.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_pwm(input int p);
        for (int k = 0; k < 16 && (cyc % 16) != p; k++) tick();
    endtask

    task automatic send(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] duty);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_duty  = duty;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'h7);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_mode  = '0;
        cfg_duty  = '0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_led", 32'(led), 32'h7);
        end

        // ch1 ON accepted at pwm_cnt=5; a ch0 request then held while not ready
        wait_pwm(5);
        chk("on_ready_before", 32'(cfg_ready), 32'h1);
        send(2'd1, 2'b01, 4'd0);
        chk("on_ready_drop", 32'(cfg_ready), 32'h0);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_mode  = 2'b01;
        wait_pwm(15);
        chk("on_ready_p15", 32'(cfg_ready), 32'h0);
        chk("on_led_p15", 32'(led), 32'h7);
        tick();
        cfg_valid = 1'b0;
        chk("on_ready_back", 32'(cfg_ready), 32'h1);
        chk("on_led_p0", 32'(led), 32'h7);
        tick();
        chk("on_led_p1", 32'(led), 32'h5);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("held_ignored", 32'(led), 32'h5);
        end

        // out-of-range channel: accepted, discarded
        send(2'd3, 2'b01, 4'd0);
        chk("badch_ready", 32'(cfg_ready), 32'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("badch_led", 32'(led), 32'h5);
            chk("badch_ready_hold", 32'(cfg_ready), 32'h1);
        end

        // ch0 PWM duty=4
        send(2'd0, 2'b11, 4'd4);
        chk("pwm_ready_drop", 32'(cfg_ready), 32'h0);
        wait_pwm(0);
        chk("pwm_ready_back", 32'(cfg_ready), 32'h1);
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("pwm4_led0", 32'(led[0]), (((cyc - 1) % 16) < 4) ? 32'h0 : 32'h1);
            chk("pwm4_led12", 32'(led[2:1]), 32'h2);
            if (led[0] == 1'b0) lows++;
        end
        chk("pwm4_lows", 32'(lows), 32'd4);

        // duty=0 is never lit
        send(2'd0, 2'b11, 4'd0);
        wait_pwm(0);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("pwm0_led0", 32'(led[0]), 32'h1);
        end

        // ch2 BLINK follows blink_ph counted from reset
        send(2'd2, 2'b10, 4'd0);
        wait_pwm(0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("blink_led2", 32'(led[2]), ((((cyc - 1) / 10) % 2) == 0) ? 32'h0 : 32'h1);
        end

        // accepted at pwm_cnt=15: must wait for the following period end
        wait_pwm(15);
        send(2'd1, 2'b00, 4'd0);
        chk("p15_ready", 32'(cfg_ready), 32'h0);
        chk("p15_led1_now", 32'(led[1]), 32'h0);
        tick();
        chk("p15_no_early", 32'(led[1]), 32'h0);
        wait_pwm(15);
        chk("p15_ready_wait", 32'(cfg_ready), 32'h0);
        chk("p15_led1_wait", 32'(led[1]), 32'h0);
        tick();
        chk("p15_ready_back", 32'(cfg_ready), 32'h1);
        tick();
        chk("p15_led1_off", 32'(led[1]), 32'h1);

        // reset while pending discards the request
        send(2'd1, 2'b01, 4'd0);
        chk("rstpend_ready", 32'(cfg_ready), 32'h0);
        tick();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("rstpend_led", 32'(led), 32'h7);
            chk("rstpend_ready_hold", 32'(cfg_ready), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
